// File: rtl/sqrt_req_ctrl_if.sv
// sqrt_req_ctrl_if: request/result handshake bundle; slave = controller side (in_valid/in_n/out_ready in, in_ready/out_* out), master = driver/consumer side
interface sqrt_req_ctrl_if;
  logic       in_valid;
  logic [3:0] in_n;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_n;
  logic [1:0] out_int;
  logic [9:0] out_frac;
  logic       out_exact;
  modport slave (
    input  in_valid, in_n, out_ready,
    output in_ready, out_valid, out_n, out_int, out_frac, out_exact
  );
  modport master (
    output in_valid, in_n, out_ready,
    input  in_ready, out_valid, out_n, out_int, out_frac, out_exact
  );
endinterface

// File: rtl/sqrt_req_ctrl.sv
// sqrt_req_ctrl: sequences single or sweep lookups into a sqrt ROM (rom_n out, rom_sq_root in) and presents registered results on bus; status busy/sweep_done/done_cnt
module sqrt_req_ctrl #(
  parameter int unsigned SWEEP_LAST = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sweep_start,
  output logic [3:0]     rom_n,
  input  logic [11:0]    rom_sq_root,
  output logic           busy,
  output logic           sweep_done,
  output logic [4:0]     done_cnt,
  sqrt_req_ctrl_if.slave bus
);
  localparam logic [3:0] LAST = 4'(SWEEP_LAST);
  typedef enum logic [1:0] {IDLE, LOOKUP, PRESENT} state_t;
  state_t      state_q, state_d;
  logic        sweep_q, sweep_d;
  logic        sweep_done_q, sweep_done_d;
  logic        out_exact_q, out_exact_d;
  logic [3:0]  rom_n_q, rom_n_d;
  logic [3:0]  out_n_q, out_n_d;
  logic [11:0] root_q, root_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        hs;
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    rom_n_d      = rom_n_q;
    sweep_done_d = 1'b0;
    hs           = state_q == PRESENT && bus.out_ready;
    case (state_q)
      IDLE:
        if (sweep_start) begin
          rom_n_d = 4'd0;
          sweep_d = 1'b1;
          state_d = LOOKUP;
        end else if (bus.in_valid) begin
          rom_n_d = bus.in_n;
          sweep_d = 1'b0;
          state_d = LOOKUP;
        end
      LOOKUP: state_d = PRESENT;
      PRESENT:
        if (bus.out_ready) begin
          if (sweep_q && rom_n_q != LAST) begin
            rom_n_d = rom_n_q + 4'd1;
            state_d = LOOKUP;
          end else begin
            sweep_done_d = sweep_q;
            sweep_d      = 1'b0;
            state_d      = IDLE;
          end
        end
      default: state_d = IDLE;
    endcase
    out_n_d     = state_q == LOOKUP ? rom_n_q : out_n_q;
    root_d      = state_q == LOOKUP ? rom_sq_root : root_q;
    out_exact_d = state_q == LOOKUP ? rom_sq_root[9:0] == 10'd0 : out_exact_q;
    cnt_d       = hs && cnt_q != 5'd31 ? cnt_q + 5'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sweep_q      <= 1'b0;
      sweep_done_q <= 1'b0;
      rom_n_q      <= 4'd0;
      out_n_q      <= 4'd0;
      root_q       <= 12'd0;
      out_exact_q  <= 1'b0;
      cnt_q        <= 5'd0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      sweep_done_q <= sweep_done_d;
      rom_n_q      <= rom_n_d;
      out_n_q      <= out_n_d;
      root_q       <= root_d;
      out_exact_q  <= out_exact_d;
      cnt_q        <= cnt_d;
    end
  end
  assign rom_n         = rom_n_q;
  assign busy          = state_q != IDLE;
  assign sweep_done    = sweep_done_q;
  assign done_cnt      = cnt_q;
  assign bus.in_ready  = state_q == IDLE && !sweep_start;
  assign bus.out_valid = state_q == PRESENT;
  assign bus.out_n     = out_n_q;
  assign bus.out_int   = root_q[11:10];
  assign bus.out_frac  = root_q[9:0];
  assign bus.out_exact = out_exact_q;
endmodule
